// File: rtl/mram_sys_ctrl.sv
// MRAM front end: SPI programming receiver, SPI/core arbitration and the
// word-wide MRAM read/write sequencer shared by both 16-bit devices.
//
// state | meaning
// IDLE  | waiting for a granted SPI write or core access
// RD1   | read: address out, output enable asserted
// RD2   | read: data settling, captured as the cycle ends
// WR_SU | write: address/data setup, write enable high
// WR_P1 | write: write enable pulse, first cycle
// WR_P2 | write: write enable pulse, second cycle
// WR_HD | write: data hold, write enable high
module mram_sys_ctrl #(
   parameter int SCLK_SYNC_STAGES = 2,
   parameter int FRAME_BITS       = 48
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        PROGRAM,
   input  logic        sclk,
   input  logic        mosi,
   output logic        miso,
   input  logic        ss,
   output logic [15:0] maddr,
   inout  wire  [31:0] mdata,
   output logic        webar,
   output logic        rebar,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [15:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        core_ack,
   input  logic        core_halt,
   output logic        suspend
);

   localparam int CW = $clog2(FRAME_BITS + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

   typedef enum logic [2:0] {IDLE, RD1, RD2, WR_SU, WR_P1, WR_P2, WR_HD} state_t;

   logic [SCLK_SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
   logic                  sclk_d;
   logic [FRAME_BITS-1:0] sr;
   logic [CW-1:0]         bit_cnt;
   logic                  sclk_s, mosi_s, ss_s, sclk_rise, sclk_fall, frame_done;
   logic [FRAME_BITS-1:0] frame_word;

   logic        pend_valid;
   logic [15:0] pend_addr;
   logic [31:0] pend_data;

   state_t      state, state_d;
   logic        grant_spi, grant_core, tail;
   logic [15:0] addr_l;
   logic [31:0] data_l;
   logic        op_spi, oe, rd_done, wr_done;

   assign sclk_s     = sclk_sync[SCLK_SYNC_STAGES-1];
   assign mosi_s     = mosi_sync[SCLK_SYNC_STAGES-1];
   assign ss_s       = ss_sync[SCLK_SYNC_STAGES-1];
   assign sclk_rise  = sclk_s & ~sclk_d;
   assign sclk_fall  = ~sclk_s & sclk_d;
   assign frame_word = {sr[FRAME_BITS-2:0], mosi_s};
   assign frame_done = ~ss_s & sclk_rise & (bit_cnt == LAST_BIT);

   always_ff @(posedge clk) begin
      if (!areset) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
         sclk_d    <= 1'b0;
         sr        <= '0;
         bit_cnt   <= '0;
         miso      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SCLK_SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SCLK_SYNC_STAGES-2:0], mosi};
         ss_sync   <= {ss_sync[SCLK_SYNC_STAGES-2:0], ss};
         sclk_d    <= sclk_s;
         if (ss_s) begin
            bit_cnt <= '0;
         end else if (sclk_rise) begin
            sr      <= frame_word;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
         end
         // sr is full-duplex, so the falling edge exposes the previous frame
         if (sclk_fall) miso <= sr[FRAME_BITS-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!areset) begin
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
      end else if (frame_done && PROGRAM) begin
         pend_valid <= 1'b1;
         pend_addr  <= frame_word[FRAME_BITS-1 -: 16];
         pend_data  <= frame_word[31:0];
      end else if ((state == WR_HD && op_spi) || (state == IDLE && !PROGRAM)) begin
         pend_valid <= 1'b0;
      end
   end

   // tail covers the cycle where the last strobe is still being retired
   assign tail = rd_done | wr_done;

   always_ff @(posedge clk) begin
      if (!areset) state <= IDLE;
      else         state <= state_d;
   end

   always_comb begin
      state_d    = state;
      grant_spi  = 1'b0;
      grant_core = 1'b0;
      case (state)
         IDLE: begin
            if (!tail) begin
               if (PROGRAM) begin
                  if (pend_valid) begin
                     grant_spi = 1'b1;
                     state_d   = WR_SU;
                  end
               end else if (core_req && !core_ack) begin
                  grant_core = 1'b1;
                  state_d    = core_we ? WR_SU : RD1;
               end
            end
         end
         RD1:     state_d = RD2;
         RD2:     state_d = IDLE;
         WR_SU:   state_d = WR_P1;
         WR_P1:   state_d = WR_P2;
         WR_P2:   state_d = WR_HD;
         WR_HD:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!areset) begin
         addr_l     <= '0;
         data_l     <= '0;
         op_spi     <= 1'b0;
         maddr      <= '0;
         webar      <= 1'b1;
         rebar      <= 1'b1;
         oe         <= 1'b0;
         rd_done    <= 1'b0;
         wr_done    <= 1'b0;
         core_ack   <= 1'b0;
         core_rdata <= '0;
         suspend    <= 1'b0;
      end else begin
         if (grant_spi) begin
            addr_l <= pend_addr;
            data_l <= pend_data;
            op_spi <= 1'b1;
         end else if (grant_core) begin
            addr_l <= core_addr;
            data_l <= core_wdata;
            op_spi <= 1'b0;
         end
         if (state != IDLE) maddr <= addr_l;
         rebar    <= !(state == RD1 || state == RD2);
         webar    <= !(state == WR_P1 || state == WR_P2);
         oe       <= (state == WR_SU || state == WR_P1 || state == WR_P2 || state == WR_HD);
         rd_done  <= (state == RD2);
         wr_done  <= (state == WR_HD);
         core_ack <= rd_done | (wr_done & ~op_spi);
         if (rd_done) core_rdata <= mdata;
         if (core_halt && !PROGRAM) suspend <= 1'b1;
      end
   end

   assign mdata = oe ? data_l : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_mram_sys_ctrl.sv
// Directed bench for mram_sys_ctrl with a two-device MRAM model on the
// shared bus and a bit-banged SPI programmer.
module tb_mram_sys_ctrl;

   logic        clk = 1'b0;
   logic        areset, PROGRAM, sclk, mosi, ss;
   logic        miso;
   logic [15:0] maddr;
   wire  [31:0] mdata;
   logic        webar, rebar;
   logic        core_req, core_we;
   logic [15:0] core_addr;
   logic [31:0] core_wdata, core_rdata;
   logic        core_ack, core_halt, suspend;

   int n_checks = 0;
   int n_fail   = 0;

   mram_sys_ctrl dut (
      .clk(clk), .areset(areset), .PROGRAM(PROGRAM), .sclk(sclk), .mosi(mosi),
      .miso(miso), .ss(ss), .maddr(maddr), .mdata(mdata), .webar(webar),
      .rebar(rebar), .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ack(core_ack),
      .core_halt(core_halt), .suspend(suspend)
   );

   always #5 clk = ~clk;

   // MRAM model: two 16-bit devices, write captured on the rising write enable
   logic [15:0] mem0 [0:63];
   logic [15:0] mem1 [0:63];
   int          wr_count = 0;
   logic [15:0] last_waddr = '0;

   assign mdata = (!rebar && webar) ? {mem1[maddr[5:0]], mem0[maddr[5:0]]} : 32'hzzzz_zzzz;

   always @(posedge webar) begin
      mem0[maddr[5:0]] <= mdata[15:0];
      mem1[maddr[5:0]] <= mdata[31:16];
      last_waddr       <= maddr;
      wr_count         <= wr_count + 1;
   end

   int we_run = 0, re_run = 0, we_len = 0, re_len = 0, overlap = 0;
   always @(negedge clk) begin
      we_run <= webar ? 0 : we_run + 1;
      re_run <= rebar ? 0 : re_run + 1;
      if (webar && we_run != 0) we_len <= we_run;
      if (rebar && re_run != 0) re_len <= re_run;
      if (!webar && !rebar) overlap <= overlap + 1;
   end

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic spi_frame(input logic [47:0] f, input int nbits, output logic [47:0] mi);
      mi = '0;
      ss = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         mosi = f[47-i];
         repeat (8) @(negedge clk);
         mi[47-i] = miso;
         sclk = 1'b1;
         repeat (8) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (8) @(negedge clk);
      ss = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic core_op(input logic we, input logic [15:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
      @(negedge clk);
      core_we = we; core_addr = a; core_wdata = d; core_req = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!core_ack && lat < 40);
      rd = core_rdata;
      core_req = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   localparam logic [47:0] FA = {16'h0003, 32'hDEAD_BEEF};
   localparam logic [47:0] FP = {16'h0009, 32'hCAFE_F00D};
   localparam logic [47:0] FB = {16'h0004, 32'h1234_5678};
   localparam logic [47:0] FZ = {16'h0000, 32'h0000_0013};

   initial begin
      vec_t        vecs [8];
      logic [47:0] mi, fa, fp;
      logic [31:0] rd;
      int          lat, base, seen;

      vecs[0] = '{1'b0, 16'd0,  32'h0,         32'h0000_0013, 4};
      vecs[1] = '{1'b1, 16'd10, 32'hA5A5_5A5A, 32'h0,         6};
      vecs[2] = '{1'b0, 16'd10, 32'h0,         32'hA5A5_5A5A, 4};
      vecs[3] = '{1'b1, 16'd11, 32'h0000_FFFF, 32'h0,         6};
      vecs[4] = '{1'b0, 16'd11, 32'h0,         32'h0000_FFFF, 4};
      vecs[5] = '{1'b0, 16'd3,  32'h0,         32'hDEAD_BEEF, 4};
      vecs[6] = '{1'b0, 16'd4,  32'h0,         32'h1234_5678, 4};
      vecs[7] = '{1'b1, 16'd0,  32'hFFFF_FFFF, 32'h0,         6};
      fa = FA;
      fp = FP;

      areset = 1'b0; PROGRAM = 1'b1; sclk = 1'b0; mosi = 1'b0; ss = 1'b1;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_halt = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_maddr", 48'(maddr), 48'h0);
      chk("rst_webar", 48'(webar), 48'h1);
      chk("rst_rebar", 48'(rebar), 48'h1);
      chk("rst_miso", 48'(miso), 48'h0);
      chk("rst_rdata", 48'(core_rdata), 48'h0);
      chk("rst_ack", 48'(core_ack), 48'h0);
      chk("rst_suspend", 48'(suspend), 48'h0);
      n_checks++;
      if (mdata !== 32'hzzzz_zzzz) begin
         n_fail++;
         $display("FAIL rst_mdata_z: got %0h expected high-Z", mdata);
      end
      areset = 1'b1;
      repeat (4) @(negedge clk);

      base = wr_count;
      spi_frame(FA, 48, mi);
      repeat (20) @(negedge clk);
      chk("spi_miso_first", mi, 48'h0);
      chk("spi_wr_count", 48'(wr_count - base), 48'd1);
      chk("spi_waddr", 48'(last_waddr), 48'h3);
      chk("spi_dev0", 48'(mem0[3]), 48'hBEEF);
      chk("spi_dev1", 48'(mem1[3]), 48'hDEAD);
      chk("spi_webar_len", 48'(we_len), 48'd2);

      base = wr_count;
      spi_frame(FP, 20, mi);
      chk("partial_miso", mi, {fa[47:28], 28'h0});
      spi_frame(FB, 48, mi);
      chk("frame_b_miso", mi, {fa[27:0], fp[47:28]});
      repeat (20) @(negedge clk);
      chk("partial_wr_count", 48'(wr_count - base), 48'd1);
      chk("partial_waddr", 48'(last_waddr), 48'h4);
      chk("partial_data", 48'({mem1[4], mem0[4]}), 48'h1234_5678);

      spi_frame(FZ, 48, mi);
      chk("preload_miso", mi, FB);
      repeat (20) @(negedge clk);

      // core request while programming must wait for run mode
      @(negedge clk);
      core_we = 1'b0; core_addr = 16'd3; core_req = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (core_ack) seen++;
      end
      chk("no_ack_in_program", 48'(seen), 48'd0);
      PROGRAM = 1'b0;
      lat = 0;
      while (!core_ack && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("wait_then_ack", 48'(core_ack), 48'h1);
      chk("wait_then_rdata", 48'(core_rdata), 48'hDEAD_BEEF);
      core_req = 1'b0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         core_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
         #1;
         chk($sformatf("vec%0d_lat", i), 48'(lat), 48'(vecs[i].exp_lat));
         if (vecs[i].we) begin
            chk($sformatf("vec%0d_webar_len", i), 48'(we_len), 48'd2);
            chk($sformatf("vec%0d_mem", i), 48'({mem1[vecs[i].addr[5:0]], mem0[vecs[i].addr[5:0]]}),
                48'(vecs[i].wdata));
         end else begin
            chk($sformatf("vec%0d_rdata", i), 48'(rd), 48'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_rebar_len", i), 48'(re_len), 48'd2);
         end
         repeat (2) @(negedge clk);
      end
      chk("no_overlap", 48'(overlap), 48'd0);

      // reset in the middle of a write pulse
      @(negedge clk);
      core_we = 1'b1; core_addr = 16'd20; core_wdata = 32'h5555_AAAA; core_req = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_webar_low", 48'(webar), 48'h0);
      areset = 1'b0; core_req = 1'b0;
      @(negedge clk);
      chk("mid_rst_webar", 48'(webar), 48'h1);
      chk("mid_rst_rebar", 48'(rebar), 48'h1);
      n_checks++;
      if (mdata !== 32'hzzzz_zzzz) begin
         n_fail++;
         $display("FAIL mid_rst_mdata_z: got %0h expected high-Z", mdata);
      end
      areset = 1'b1;
      repeat (4) @(negedge clk);

      PROGRAM = 1'b0;
      core_halt = 1'b1;
      @(negedge clk);
      core_halt = 1'b0;
      chk("halt_suspend", 48'(suspend), 48'h1);
      repeat (5) @(negedge clk);
      chk("halt_sticky", 48'(suspend), 48'h1);
      areset = 1'b0;
      @(negedge clk);
      chk("halt_reset_clears", 48'(suspend), 48'h0);
      areset = 1'b1;
      PROGRAM = 1'b1;
      @(negedge clk);
      core_halt = 1'b1;
      @(negedge clk);
      core_halt = 1'b0;
      repeat (3) @(negedge clk);
      chk("halt_in_program", 48'(suspend), 48'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
